// File: rtl/plane_setup_ctrl.sv
// plane_setup_ctrl
// Sequences a shared plane-setup datapath once per attribute plane of a
// triangle job, then walks every pixel of the job's square tile in raster
// order (x fastest). All outputs are decoded from state/counter flops only.

module plane_setup_ctrl #(
  parameter int SETUP_LAT      = 4,  // cycles from setup strobe to capture (1..15)
  parameter int TILE_SIZE_LOG2 = 5   // tile edge is 2^TILE_SIZE_LOG2 pixels
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        tri_valid,
  output logic        tri_ready,
  input  logic [3:0]  tri_planes,
  input  logic [5:0]  tile_x,
  input  logic [5:0]  tile_y,
  input  logic        flush,
  output logic        setup,
  output logic [2:0]  plane_sel,
  output logic        plane_we,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic [10:0] x_ps,
  output logic [10:0] y_ps,
  output logic        pix_last,
  output logic        busy,
  output logic        done
);

  localparam int TS = TILE_SIZE_LOG2;

  // Last value of the wait counter before moving to CAPTURE; the wait state
  // lasts SETUP_LAT-1 cycles. Unused when SETUP_LAT is 1 (wait is skipped).
  localparam logic [3:0]    WAIT_LAST = 4'(SETUP_LAT - 2);
  localparam bit            LAT_ONE   = (SETUP_LAT == 1);
  localparam logic [TS-1:0] OFF_MAX   = {TS{1'b1}};
  localparam logic [3:0]    MAX_PLANES = 4'd8;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    SETUP_ISSUE = 3'd1,
    SETUP_WAIT  = 3'd2,
    CAPTURE     = 3'd3,
    RASTER      = 3'd4,
    DONE        = 3'd5
  } state_t;

  state_t        r_state;
  logic [2:0]    r_plane;
  logic [3:0]    r_nplanes;
  logic [3:0]    r_wait;
  logic [5:0]    r_tile_x;
  logic [5:0]    r_tile_y;
  logic [TS-1:0] r_xo;
  logic [TS-1:0] r_yo;

  state_t        w_state;
  logic [2:0]    w_plane;
  logic [3:0]    w_nplanes;
  logic [3:0]    w_wait;
  logic [5:0]    w_tile_x;
  logic [5:0]    w_tile_y;
  logic [TS-1:0] w_xo;
  logic [TS-1:0] w_yo;
  logic [3:0]    w_planes_clamped;
  logic          w_more_planes;
  logic          w_tile_end;

  // Jobs asking for more than eight planes are limited to eight.
  always_comb begin
    if (tri_planes > MAX_PLANES) begin
      w_planes_clamped = MAX_PLANES;
    end else begin
      w_planes_clamped = tri_planes;
    end
  end

  assign w_more_planes = (({1'b0, r_plane} + 4'd1) < r_nplanes);
  assign w_tile_end    = (r_xo == OFF_MAX) && (r_yo == OFF_MAX);

  // Next-state and next-counter logic; flush outranks every other transition.
  always_comb begin
    w_state   = r_state;
    w_plane   = r_plane;
    w_nplanes = r_nplanes;
    w_wait    = r_wait;
    w_tile_x  = r_tile_x;
    w_tile_y  = r_tile_y;
    w_xo      = r_xo;
    w_yo      = r_yo;

    if (flush && (r_state != IDLE)) begin
      w_state = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (tri_valid) begin
            w_nplanes = w_planes_clamped;
            w_tile_x  = tile_x;
            w_tile_y  = tile_y;
            w_plane   = 3'd0;
            w_wait    = 4'd0;
            w_xo      = {TS{1'b0}};
            w_yo      = {TS{1'b0}};
            if (w_planes_clamped == 4'd0) begin
              w_state = RASTER;
            end else begin
              w_state = SETUP_ISSUE;
            end
          end else begin
            w_state = IDLE;
          end
        end

        SETUP_ISSUE: begin
          w_wait = 4'd0;
          if (LAT_ONE) begin
            w_state = CAPTURE;
          end else begin
            w_state = SETUP_WAIT;
          end
        end

        SETUP_WAIT: begin
          if (r_wait == WAIT_LAST) begin
            w_state = CAPTURE;
          end else begin
            w_wait = r_wait + 4'd1;
          end
        end

        CAPTURE: begin
          // plane_sel only moves here, after the capture strobe of its plane.
          if (w_more_planes) begin
            w_plane = r_plane + 3'd1;
            w_state = SETUP_ISSUE;
          end else begin
            w_state = RASTER;
          end
        end

        RASTER: begin
          if (pix_ready) begin
            if (w_tile_end) begin
              w_state = DONE;
            end else if (r_xo == OFF_MAX) begin
              w_xo = {TS{1'b0}};
              w_yo = r_yo + {{(TS-1){1'b0}}, 1'b1};
            end else begin
              w_xo = r_xo + {{(TS-1){1'b0}}, 1'b1};
            end
          end else begin
            w_state = RASTER;
          end
        end

        DONE: begin
          w_state = IDLE;
        end

        default: begin
          w_state = IDLE;
        end
      endcase
    end
  end

  // State and counter registers; reset returns to an empty IDLE controller.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_plane   <= 3'd0;
      r_nplanes <= 4'd0;
      r_wait    <= 4'd0;
      r_tile_x  <= 6'd0;
      r_tile_y  <= 6'd0;
      r_xo      <= {TS{1'b0}};
      r_yo      <= {TS{1'b0}};
    end else begin
      r_state   <= w_state;
      r_plane   <= w_plane;
      r_nplanes <= w_nplanes;
      r_wait    <= w_wait;
      r_tile_x  <= w_tile_x;
      r_tile_y  <= w_tile_y;
      r_xo      <= w_xo;
      r_yo      <= w_yo;
    end
  end

  // Output decode straight from flops: no input reaches an output.
  assign tri_ready = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign setup     = (r_state == SETUP_ISSUE);
  assign plane_we  = (r_state == CAPTURE);
  assign done      = (r_state == DONE);
  assign pix_valid = (r_state == RASTER);
  assign pix_last  = (r_state == RASTER) && w_tile_end;
  assign plane_sel = r_plane;

  // Tile index in the upper bits, in-tile offset in the lower bits; index 63
  // with offset 31 gives 2047 exactly.
  assign x_ps = 11'({r_tile_x, r_xo});
  assign y_ps = 11'({r_tile_y, r_yo});

endmodule

// File: tb/tb_plane_setup_ctrl.sv
// Directed bench for plane_setup_ctrl with an event scoreboard: the driver
// pushes every expected setup/plane_we/pixel/done event when a job starts;
// a negedge monitor pops and compares them as the DUT produces them.

module tb_plane_setup_ctrl;

  localparam int LAT = 4;

  localparam int EV_SETUP = 0;
  localparam int EV_WE    = 1;
  localparam int EV_PIX   = 2;
  localparam int EV_DONE  = 3;

  typedef struct {
    int kind;
    int cyc;   // exact cycle, -1 = any, -2 = one after previous event
    int sel;
    int x;
    int y;
    int last;
  } ev_t;

  logic        clock;
  logic        reset;
  logic        tri_valid;
  logic        tri_ready;
  logic [3:0]  tri_planes;
  logic [5:0]  tile_x;
  logic [5:0]  tile_y;
  logic        flush;
  logic        setup;
  logic [2:0]  plane_sel;
  logic        plane_we;
  logic        pix_valid;
  logic        pix_ready;
  logic [10:0] x_ps;
  logic [10:0] y_ps;
  logic        pix_last;
  logic        busy;
  logic        done;

  ev_t q[$];
  int  vectors     = 0;
  int  miscompares = 0;
  int  cyc         = 0;
  int  last_cyc    = 0;
  bit  rdy_mode    = 1'b0;

  plane_setup_ctrl #(.SETUP_LAT(LAT), .TILE_SIZE_LOG2(5)) dut (
    .clock     (clock),
    .reset     (reset),
    .tri_valid (tri_valid),
    .tri_ready (tri_ready),
    .tri_planes(tri_planes),
    .tile_x    (tile_x),
    .tile_y    (tile_y),
    .flush     (flush),
    .setup     (setup),
    .plane_sel (plane_sel),
    .plane_we  (plane_we),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .x_ps      (x_ps),
    .y_ps      (y_ps),
    .pix_last  (pix_last),
    .busy      (busy),
    .done      (done)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    forever begin
      @(posedge clock);
      cyc = cyc + 1;
    end
  end

  // Pseudo-random downstream back-pressure, changed mid-cycle.
  initial begin
    forever begin
      @(posedge clock);
      #3;
      if (rdy_mode) pix_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed no end of test, expected completion");
    $fatal(1);
  end

  function automatic void push(input int k, input int c, input int s,
                               input int x, input int y, input int l);
    ev_t e;
    e.kind = k; e.cyc = c; e.sel = s; e.x = x; e.y = y; e.last = l;
    q.push_back(e);
  endfunction

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_ev(input int kind, input int sel, input int x, input int y, input int last);
    ev_t e;
    bit  cyc_ok;
    vectors++;
    assert (q.size() != 0) else begin
      miscompares++;
      $error("FAIL unexpected_event: observed kind %0d sel %0d (%0d,%0d) at cycle %0d, expected none",
             kind, sel, x, y, cyc);
    end
    if (q.size() != 0) begin
      e = q.pop_front();
      if (e.cyc == -2)      cyc_ok = (cyc == last_cyc + 1);
      else if (e.cyc == -1) cyc_ok = 1'b1;
      else                  cyc_ok = (cyc == e.cyc);
      vectors++;
      assert (kind == e.kind && sel == e.sel && x == e.x && y == e.y && last == e.last && cyc_ok) else begin
        miscompares++;
        $error("FAIL event: observed kind %0d sel %0d xy (%0d,%0d) last %0d cyc %0d, expected kind %0d sel %0d xy (%0d,%0d) last %0d cyc %0d",
               kind, sel, x, y, last, cyc, e.kind, e.sel, e.x, e.y, e.last, e.cyc);
      end
      last_cyc = cyc;
    end
  endtask

  // Monitor: every strobe or accepted pixel must match the scoreboard head.
  initial begin
    forever begin
      @(negedge clock);
      if (setup === 1'b1)    chk_ev(EV_SETUP, int'(plane_sel), 0, 0, 0);
      if (plane_we === 1'b1) chk_ev(EV_WE, int'(plane_sel), 0, 0, 0);
      if (pix_valid === 1'b1 && pix_ready === 1'b1) begin
        chk_ev(EV_PIX, 0, int'(x_ps), int'(y_ps), int'(pix_last));
      end else if (pix_valid === 1'b1) begin
        vectors++;
        assert (q.size() != 0 && q[0].kind == EV_PIX && int'(x_ps) == q[0].x && int'(y_ps) == q[0].y) else begin
          miscompares++;
          $error("FAIL stall_hold: observed (%0d,%0d) during stall, expected head pixel held", x_ps, y_ps);
        end
      end
      if (done === 1'b1) begin
        chk_ev(EV_DONE, 0, 0, 0, 0);
        vectors++;
        assert (tri_ready === 1'b0 && busy === 1'b1) else begin
          miscompares++;
          $error("FAIL done_no_accept: observed tri_ready %b busy %b, expected 0 1", tri_ready, busy);
        end
      end
    end
  end

  task automatic start_job(input int np_raw, input int tx, input int ty, input bit fixed, output int base);
    int n;
    int np;
    int first;
    n = 0;
    @(negedge clock);
    while (tri_ready !== 1'b1 && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk_val("accept_ready", 32'(tri_ready), 32'd1);
    tri_planes = 4'(np_raw);
    tile_x     = 6'(tx);
    tile_y     = 6'(ty);
    tri_valid  = 1'b1;
    base       = cyc;
    np = (np_raw > 8) ? 8 : np_raw;
    for (int p = 0; p < np; p++) begin
      push(EV_SETUP, base + 1 + p * (LAT + 1), p, 0, 0, 0);
      push(EV_WE, base + LAT + 1 + p * (LAT + 1), p, 0, 0, 0);
    end
    first = base + 1 + np * (LAT + 1);
    for (int yy = 0; yy < 32; yy++) begin
      for (int xx = 0; xx < 32; xx++) begin
        push(EV_PIX, fixed ? first + yy * 32 + xx : -1, 0, tx * 32 + xx, ty * 32 + yy,
             (xx == 31 && yy == 31) ? 1 : 0);
      end
    end
    push(EV_DONE, -2, 0, 0, 0, 0);
    @(posedge clock);
    #1 tri_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n;
    n = 0;
    while (q.size() != 0 && n < budget) begin
      @(negedge clock);
      n++;
    end
    chk_val(tag, 32'(q.size()), 32'd0);
    @(negedge clock);
    chk_val("idle_ready", 32'(tri_ready), 32'd1);
    chk_val("idle_busy", 32'(busy), 32'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk_val({tag, "_tri_ready"}, 32'(tri_ready), 32'd1);
    chk_val({tag, "_setup"},     32'(setup),     32'd0);
    chk_val({tag, "_plane_we"},  32'(plane_we),  32'd0);
    chk_val({tag, "_pix_valid"}, 32'(pix_valid), 32'd0);
    chk_val({tag, "_pix_last"},  32'(pix_last),  32'd0);
    chk_val({tag, "_busy"},      32'(busy),      32'd0);
    chk_val({tag, "_done"},      32'(done),      32'd0);
    chk_val({tag, "_plane_sel"}, 32'(plane_sel), 32'd0);
    chk_val({tag, "_x_ps"},      32'(x_ps),      32'd0);
    chk_val({tag, "_y_ps"},      32'(y_ps),      32'd0);
  endtask

  initial begin
    int base;
    reset      = 1'b1;
    tri_valid  = 1'b0;
    tri_planes = 4'd0;
    tile_x     = 6'd0;
    tile_y     = 6'd0;
    flush      = 1'b0;
    pix_ready  = 1'b1;

    // Reset values.
    #12;
    chk_reset_vals("rst");
    @(posedge clock);
    #2 reset = 1'b0;

    // Three planes, full-rate downstream: exact strobe and pixel timing.
    start_job(3, 5, 7, 1'b1, base);
    wait_done(3000, "job3_complete");

    // No planes: raster starts one cycle after accept at (64,32).
    start_job(0, 2, 1, 1'b1, base);
    wait_done(3000, "job0_complete");

    // Clamp 12 -> 8 planes, max tile index, random back-pressure.
    rdy_mode = 1'b1;
    start_job(12, 63, 63, 1'b0, base);
    wait_done(8000, "job12_complete");
    rdy_mode = 1'b0;
    @(posedge clock);
    #1 pix_ready = 1'b1;

    // Flush during the wait of plane 1.
    start_job(3, 1, 1, 1'b1, base);
    while (cyc < base + 8) @(negedge clock);
    flush = 1'b1;
    @(posedge clock);
    #1 flush = 1'b0;
    chk_val("flush_setup_remaining", 32'(q.size()), 32'd1028);
    q.delete();
    @(negedge clock);
    chk_val("flush1_ready", 32'(tri_ready), 32'd1);
    chk_val("flush1_busy",  32'(busy),      32'd0);
    repeat (20) @(negedge clock);

    // Flush while pixel 500 is presented.
    start_job(0, 3, 4, 1'b1, base);
    while (cyc < base + 501) @(negedge clock);
    flush = 1'b1;
    @(posedge clock);
    #1 flush = 1'b0;
    chk_val("flush_pix_remaining", 32'(q.size()), 32'd524);
    q.delete();
    @(negedge clock);
    chk_val("flush2_ready",     32'(tri_ready), 32'd1);
    chk_val("flush2_pix_valid", 32'(pix_valid), 32'd0);
    repeat (20) @(negedge clock);

    // Asynchronous reset mid-raster, then a normal job.
    start_job(1, 4, 5, 1'b1, base);
    while (cyc < base + 300) @(negedge clock);
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    chk_reset_vals("midrst");
    q.delete();
    repeat (2) @(posedge clock);
    #2 reset = 1'b0;
    start_job(2, 0, 0, 1'b1, base);
    wait_done(3000, "post_reset_complete");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
